s2c_pkt_serializer: RTL
=======================

# s2c_pkt_serializer

Converts one software-to-chip packet (id, fn, ret, up to 16 data words) into a 32-bit word stream with valid/ready handshake and start/end markers. Sits directly downstream of the s2c DPI interface. A bench-side driver loads the packet returned by a function call, and this block feeds the DUT's stream input one word per cycle. Packets whose ret field is non-zero are dropped and counted, not emitted.

## Interface
Parameters:
- DATA_WORDS, 16: maximum data words per packet; equals the shared S2C data size.
- WORD_W, 32: stream word width; fixed at 32 for the s2c packet format.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  packet load request.
- in_ready  out  1  block can accept a packet this cycle.
- in_id  in  32  packet id.
- in_fn  in  32  function code.
- in_ret  in  32  return status; non-zero means drop.
- in_len  in  5  number of valid data words, 0..DATA_WORDS.
- in_data  in  DATA_WORDS*32  data words; word k is at bits [32k+31:32k].
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  32  stream word.
- out_sop  out  1  first word of a packet.
- out_eop  out  1  last word of a packet.
- pkt_cnt  out  16  packets fully emitted; wraps.
- drop_cnt  out  16  packets dropped because ret != 0; wraps.
- len_err  out  1  sticky; set when a loaded in_len exceeds DATA_WORDS.

## Operation
- States: IDLE, HDR_ID, HDR_FN, DATA.
- Load handshake: in_valid && in_ready captures id, fn, len, and all data words into internal registers.
- Dropped packet: if in_ret != 0 at load, nothing is registered, drop_cnt increments by 1, and the state stays or returns to IDLE.
- Normal packet: if in_ret == 0 at load, the block goes to HDR_ID.
- Stream order: word0 = id (out_sop=1), word1 = fn, then data[0..len-1]. out_eop is set on the final word, which is word1 when len == 0.
- in_len > DATA_WORDS: len is clamped to DATA_WORDS and len_err is set. len_err clears only on reset.
- Data index counter: 5 bits, counting 0..len-1. The block leaves DATA when the counter reaches len-1 with an out handshake.
- pkt_cnt increments on the out handshake of the eop word.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_eop), so a new packet can load on the same cycle the previous eop word is accepted.
- Back-to-back: if a packet loads on the eop handshake cycle, the next cycle goes straight to HDR_ID.
- Simultaneous eop handshake and dropped load: pkt_cnt and drop_cnt both increment, and the next state is IDLE.

## Timing
- Reset values (async, immediate): state IDLE; out_valid 0; out_sop 0; out_eop 0; out_data 0; pkt_cnt 0; drop_cnt 0; len_err 0. in_ready becomes 1 after reset is released.
- Latency: packet loaded at edge N → first word valid after edge N, so it is visible in cycle N+1.
- Throughput: with out_ready held high, a packet of len L occupies L+2 cycles. Back-to-back packets have no gap cycle.
- Stability: while out_valid && !out_ready, out_data, out_sop and out_eop hold unchanged and out_valid stays 1.
- out_valid does not depend combinationally on out_ready. in_ready may depend combinationally on out_ready, via the eop path only.
- Reset mid-packet: the stream is truncated immediately with no eop. The partial packet is not counted.

## Structure
- Shared package s2c_pkg: S2C_DATA_SIZE = 16, S2C_WORD_W = 32, the state enum (IDLE, HDR_ID, HDR_FN, DATA), and the header word-order constants. The DPI packet struct and this block both use S2C_DATA_SIZE from this package.
- Single module, no sub-module. The output word is a registered mux over the header and data registers, selected by state and index.

## Test plan
- Basic: id=0x11, fn=1, ret=0, len=3, data=A0,A1,A2, out_ready=1 → words 0x11, 1, A0, A1, A2 on 5 consecutive cycles; sop on 0x11; eop on A2; pkt_cnt=1.
- Zero length: len=0, id=5, fn=2 → exactly 2 words; eop on fn=2; pkt_cnt increments.
- Drop: ret=0x3 → no out_valid; drop_cnt=1; in_ready stays 1.
- Backpressure: len=16, out_ready toggles 1,0,0,1 repeating → 18 words in order; data stable while stalled; no duplicated or lost words.
- Back-to-back and clamp: second packet presented on the first packet's eop cycle → no gap. A packet with len=20 → 16 data words emitted and len_err=1.
- Reset mid-packet: assert rst_n low after the third word → out_valid drops at once; counters read 0; the next packet streams normally.

Source files
------------

// File: rtl/s2c_pkg.sv
// Shared definitions for the software-to-chip packet path: sizes, the
// serializer state encoding and the header word layout.
package s2c_pkg;

  localparam int S2C_DATA_SIZE = 16;
  localparam int S2C_WORD_W    = 32;

  // Header words precede the data words on the stream, id first.
  localparam int S2C_HDR_ID_POS = 0;
  localparam int S2C_HDR_FN_POS = 1;
  localparam int S2C_HDR_WORDS  = S2C_HDR_FN_POS - S2C_HDR_ID_POS + 1;

  typedef enum logic [1:0] {
    IDLE,
    HDR_ID,
    HDR_FN,
    DATA
  } s2c_state_e;

  // Limit a requested data length to the capacity of the packet.
  function automatic logic [4:0] s2c_clamp_len(input logic [4:0] len,
                                               input logic [4:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  // Total stream words for a packet carrying len data words.
  function automatic int s2c_pkt_words(input logic [4:0] len);
    return int'(len) + S2C_HDR_WORDS;
  endfunction

endpackage

// File: rtl/s2c_pkt_serializer.sv
// Turns one loaded s2c packet into a stream of 32-bit words: id, fn, then
// len data words, with sop on the id word and eop on the last word.
// Packets with a non-zero return status are dropped and only counted.
module s2c_pkt_serializer
  import s2c_pkg::*;
#(
  parameter int DATA_WORDS = S2C_DATA_SIZE,
  parameter int WORD_W     = S2C_WORD_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_W-1:0]            in_id,
  input  logic [WORD_W-1:0]            in_fn,
  input  logic [WORD_W-1:0]            in_ret,
  input  logic [4:0]                   in_len,
  input  logic [DATA_WORDS*WORD_W-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_W-1:0]            out_data,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [15:0]                  pkt_cnt,
  output logic [15:0]                  drop_cnt,
  output logic                         len_err
);

  localparam int         IDX_W   = $clog2(DATA_WORDS);
  localparam logic [4:0] MAX_LEN = 5'(DATA_WORDS);

  s2c_state_e state, state_nxt;

  logic [WORD_W-1:0]                  fn_r;
  logic [4:0]                         len_r;
  logic [DATA_WORDS-1:0][WORD_W-1:0]  data_r;
  logic [4:0]                         idx_r, idx_nxt, idx_inc, len_last;

  logic              valid_nxt, sop_nxt, eop_nxt;
  logic [WORD_W-1:0] data_nxt;

  logic out_hs, eop_hs, load, load_ok, load_drop;

  assign out_hs    = out_valid && out_ready;
  assign eop_hs    = out_hs && out_eop;
  assign in_ready  = (state == IDLE) || eop_hs;
  assign load      = in_valid && in_ready;
  assign load_ok   = load && (in_ret == '0);
  assign load_drop = load && (in_ret != '0);
  assign idx_inc   = idx_r + 5'd1;
  assign len_last  = len_r - 5'd1;

  // Next state and next presented word; a new load overrides the tail of the old packet.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_r;
    valid_nxt = out_valid;
    data_nxt  = out_data;
    sop_nxt   = out_sop;
    eop_nxt   = out_eop;

    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        sop_nxt   = 1'b0;
        eop_nxt   = 1'b0;
      end
      HDR_ID: begin
        if (out_hs) begin
          state_nxt = HDR_FN;
          data_nxt  = fn_r;
          sop_nxt   = 1'b0;
          eop_nxt   = (len_r == 5'd0);
        end
      end
      HDR_FN: begin
        if (out_hs) begin
          if (len_r == 5'd0) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            eop_nxt   = 1'b0;
          end else begin
            state_nxt = DATA;
            idx_nxt   = 5'd0;
            data_nxt  = data_r[0];
            eop_nxt   = (len_r == 5'd1);
          end
        end
      end
      DATA: begin
        if (out_hs) begin
          if (idx_r == len_last) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            eop_nxt   = 1'b0;
          end else begin
            idx_nxt  = idx_inc;
            data_nxt = data_r[idx_inc[IDX_W-1:0]];
            eop_nxt  = (idx_inc == len_last);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        sop_nxt   = 1'b0;
        eop_nxt   = 1'b0;
      end
    endcase

    if (load_ok) begin
      state_nxt = HDR_ID;
      valid_nxt = 1'b1;
      data_nxt  = in_id;
      sop_nxt   = 1'b1;
      eop_nxt   = 1'b0;
    end
  end

  // State, output word register, status counters and sticky length error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx_r     <= 5'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      pkt_cnt   <= 16'd0;
      drop_cnt  <= 16'd0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx_r     <= idx_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      out_sop   <= sop_nxt;
      out_eop   <= eop_nxt;
      if (eop_hs) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (load_drop) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (load_ok && (in_len > MAX_LEN)) begin
        len_err <= 1'b1;
      end
    end
  end

  // Packet payload capture; only meaningful while a packet is in flight, so no reset.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      fn_r   <= in_fn;
      len_r  <= s2c_clamp_len(in_len, MAX_LEN);
      data_r <= in_data;
    end
  end

endmodule
